// File: rtl/q2_lcd_io.sv
// Console peripheral at q2 address 0xFFF: queues CPU character/command writes and
// serialises them to an HD44780-style LCD in 4-bit mode; reads return debounced keys.
module q2_lcd_io #(
    parameter int FIFO_DEPTH = 8,
    parameter int KEYS       = 4,
    parameter int DEB_CYC    = 16,
    parameter int E_CYC      = 2,
    parameter int CHAR_CYC   = 4,
    parameter int CLR_CYC    = 64,
    parameter int PWR_CYC    = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     abus,
    input  logic [11:0]     dbus_in,
    input  logic            wrm,
    input  logic            rdm,
    output logic [11:0]     dbus_out,
    output logic            dbus_oe,
    input  logic [KEYS-1:0] keys_n,
    output logic            lcd_rs,
    output logic            lcd_e,
    output logic [3:0]      lcd_d,
    output logic            lcd_ready
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
    localparam int M1   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int M2   = (CHAR_CYC > E_CYC) ? CHAR_CYC : E_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] PWR_LAST  = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] CHAR_LAST = CW'(CHAR_CYC - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(E_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [11:0]   MY_ADDR   = 12'hFFF;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_E,
        ST_INIT_GAP,
        ST_IDLE,
        ST_NIB_HI,
        ST_GAP1,
        ST_NIB_LO,
        ST_WAIT
    } state_t;

    function automatic logic [7:0] printable(input logic [7:0] c);
        return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h3F;
    endfunction

    // Returns {valid, rs, byte} for a CPU write word.
    function automatic logic [9:0] decode_write(input logic [8:0] d);
        logic [9:0] r;
        r = '0;
        if (!d[8])
            r = {1'b1, 1'b1, printable(d[7:0])};
        else if (d[7])
            r = {1'b1, 1'b0, 1'b1, d[6:0]};
        else if (d[0])
            r = {1'b1, 1'b0, 8'h01};
        return r;
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = 8'h28;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h06;
            default: b = 8'h01;
        endcase
        return b;
    endfunction

    // ---------------- write strobe edge detect and decode ----------------
    logic       wrm_q, wrm_d;
    logic       wr_req;
    logic [9:0] wr_dec;
    logic       unused_bits;

    assign wrm_d       = wrm;
    assign wr_dec      = decode_write(dbus_in[8:0]);
    assign wr_req      = wrm && !wrm_q && (abus == MY_ADDR) && wr_dec[9];
    assign unused_bits = ^dbus_in[11:9];

    always_ff @(posedge clk) begin
        if (rst) wrm_q <= 1'b0;
        else     wrm_q <= wrm_d;
    end

    // ---------------- write queue ----------------
    state_t        state_q;
    logic          init_done_q;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          fifo_full, fifo_empty, enq, deq;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign deq        = (state_q == ST_IDLE) && init_done_q && !fifo_empty;
    // A full queue still takes the write when an entry leaves in the same cycle.
    assign enq        = wr_req && (!fifo_full || deq);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= wr_dec[8:0];
    end

    // ---------------- keypad synchroniser and debounce ----------------
    logic [KEYS-1:0] sync1_q, sync2_q, deb_q, deb_d;
    logic [DW-1:0]   dcnt_q [KEYS];
    logic [DW-1:0]   dcnt_d [KEYS];

    // The counter runs only while the synchronised input disagrees with the debounced value.
    always_comb begin
        for (int k = 0; k < KEYS; k++) begin
            deb_d[k]  = deb_q[k];
            dcnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (dcnt_q[k] == DEB_LAST) deb_d[k] = sync2_q[k];
                else                       dcnt_d[k] = dcnt_q[k] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            for (int k = 0; k < KEYS; k++) dcnt_q[k] <= '0;
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // ---------------- CPU read path ----------------
    always_comb begin
        dbus_out             = '1;
        dbus_out[KEYS-1:0]   = deb_q;
        dbus_out[11]         = !fifo_full;
    end

    assign dbus_oe = rdm && (abus == MY_ADDR);

    // ---------------- LCD serialiser ----------------
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [7:0]    cur_byte_q;
    logic          cur_rs_q;
    logic          lcd_e_q, lcd_rs_q;
    logic [3:0]    lcd_d_q;
    logic [8:0]    next_ent;
    logic [CW-1:0] wait_last;

    // During init the byte path is fed from the fixed init table instead of the queue.
    assign next_ent  = init_done_q ? mem_q[rd_ptr_q] : {1'b0, init_byte(idx_q)};
    assign wait_last = (cur_byte_q == 8'h01 && !cur_rs_q) ? CLR_LAST : CHAR_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            cur_rs_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_d_q     <= '0;
        end else begin
            case (state_q)
                ST_PWR_WAIT: begin
                    if (cnt_q == PWR_LAST) begin
                        cnt_q    <= '0;
                        lcd_e_q  <= 1'b1;
                        lcd_rs_q <= 1'b0;
                        lcd_d_q  <= init_nibble(idx_q);
                        state_q  <= ST_INIT_E;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_INIT_E: begin
                    if (cnt_q == E_LAST) begin
                        cnt_q   <= '0;
                        lcd_e_q <= 1'b0;
                        state_q <= ST_INIT_GAP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_INIT_GAP: begin
                    if (cnt_q == CLR_LAST) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                        end else begin
                            lcd_e_q <= 1'b1;
                            lcd_d_q <= init_nibble(idx_q + 2'd1);
                            state_q <= ST_INIT_E;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (!init_done_q || !fifo_empty) begin
                        cur_rs_q   <= next_ent[8];
                        cur_byte_q <= next_ent[7:0];
                        lcd_rs_q   <= next_ent[8];
                        lcd_d_q    <= next_ent[7:4];
                        lcd_e_q    <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_NIB_HI;
                        if (!init_done_q) begin
                            idx_q <= idx_q + 2'd1;
                            if (idx_q == 2'd3) init_done_q <= 1'b1;
                        end
                    end
                end
                ST_NIB_HI: begin
                    if (cnt_q == E_LAST) begin
                        cnt_q   <= '0;
                        lcd_e_q <= 1'b0;
                        state_q <= ST_GAP1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP1: begin
                    lcd_d_q <= cur_byte_q[3:0];
                    lcd_e_q <= 1'b1;
                    state_q <= ST_NIB_LO;
                end
                ST_NIB_LO: begin
                    if (cnt_q == E_LAST) begin
                        cnt_q   <= '0;
                        lcd_e_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == wait_last) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= ST_PWR_WAIT;
            endcase
        end
    end

    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_d     = lcd_d_q;
    assign lcd_ready = (state_q == ST_IDLE) && init_done_q && fifo_empty;

endmodule

// File: tb/tb_q2_lcd_io.sv
// Bench for q2_lcd_io: random CPU writes and key activity, with an expected-nibble
// scoreboard consumed by an independent LCD bus monitor.
module tb_q2_lcd_io;

    localparam int FIFO_DEPTH = 8;
    localparam int KEYS       = 4;
    localparam int DEB_CYC    = 16;
    localparam int E_CYC      = 2;
    localparam int CHAR_CYC   = 4;
    localparam int CLR_CYC    = 64;
    localparam int PWR_CYC    = 256;
    localparam int LIMIT      = 20000;

    logic            clk = 1'b0;
    logic            rst;
    logic [11:0]     abus, dbus_in, dbus_out;
    logic            wrm, rdm, dbus_oe;
    logic [KEYS-1:0] keys_n;
    logic            lcd_rs, lcd_e, lcd_ready;
    logic [3:0]      lcd_d;

    always #5 clk = ~clk;

    q2_lcd_io #(
        .FIFO_DEPTH(FIFO_DEPTH), .KEYS(KEYS), .DEB_CYC(DEB_CYC), .E_CYC(E_CYC),
        .CHAR_CYC(CHAR_CYC), .CLR_CYC(CLR_CYC), .PWR_CYC(PWR_CYC)
    ) dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in), .wrm(wrm), .rdm(rdm),
        .dbus_out(dbus_out), .dbus_oe(dbus_oe), .keys_n(keys_n), .lcd_rs(lcd_rs),
        .lcd_e(lcd_e), .lcd_d(lcd_d), .lcd_ready(lcd_ready)
    );

    // kind: 0 = init nibble, 1 = high nibble of a byte, 2 = low nibble of a byte
    typedef struct packed {
        logic        rs;
        logic [3:0]  nib;
        logic [15:0] mingap;
        logic [1:0]  kind;
    } exp_t;

    exp_t            exp_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              rise_cnt = 0;
    logic [KEYS-1:0] key_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back('{rs: rs, nib: b[7:4], mingap: 16'd1, kind: 2'd1});
        exp_q.push_back('{rs: rs, nib: b[3:0],
                          mingap: (b == 8'h01 && !rs) ? 16'(CLR_CYC) : 16'(CHAR_CYC), kind: 2'd2});
    endtask

    task automatic push_init();
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{rs: 1'b0, nib: (i == 3) ? 4'h2 : 4'h3, mingap: 16'(CLR_CYC), kind: 2'd0});
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
    endtask

    // Reference decode of one CPU write into what the LCD should receive.
    task automatic model_write(input logic [11:0] a, input logic [11:0] d);
        int c;
        if (a != 12'hFFF) return;
        if (d[8] == 1'b0) begin
            c = int'(d[7:0]);
            if (c < 32 || c > 126) c = 63;
            push_byte(1'b1, 8'(c));
        end else if (d[7]) begin
            push_byte(1'b0, 8'(128 + int'(d[6:0])));
        end else if (d[0]) begin
            push_byte(1'b0, 8'h01);
        end
    endtask

    function automatic logic [11:0] exp_read(input logic nf);
        logic [11:0] r;
        r = 12'hFFF;
        r[KEYS-1:0] = key_model;
        r[11] = nf;
        return r;
    endfunction

    // ---------------- LCD bus monitor ----------------
    bit         in_pulse = 0, gap_act = 0, first_pend = 1, stable;
    int         width, gap, pwr_cnt = 0;
    logic       cap_rs;
    logic [3:0] cap_d;
    exp_t       g;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_pulse = 0; gap_act = 0; first_pend = 1; pwr_cnt = 0;
        end else if (lcd_e) begin
            if (!in_pulse) begin
                rise_cnt++;
                if (first_pend) begin
                    check("pwr_wait_len", pwr_cnt, PWR_CYC);
                    first_pend = 0;
                end
                if (gap_act) begin
                    if (g.kind == 2'd1) check("gap1_len", gap, 1);
                    else                check("gap_min", 32'(gap >= int'(g.mingap)), 1);
                end
                gap_act = 0; in_pulse = 1; width = 1; stable = 1;
                cap_rs = lcd_rs; cap_d = lcd_d;
            end else begin
                width++;
                if (lcd_rs !== cap_rs || lcd_d !== cap_d) stable = 0;
            end
        end else begin
            if (first_pend) pwr_cnt++;
            if (in_pulse) begin
                in_pulse = 0;
                if (lcd_rs !== cap_rs || lcd_d !== cap_d) stable = 0;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_nibble: got rs=%0d d=%0h, expected none", cap_rs, cap_d);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble_rs", cap_rs, e.rs);
                    check("nibble_d", cap_d, e.nib);
                    check("e_width", width, E_CYC);
                    check("nibble_stable", stable, 1);
                    g = e; gap_act = 1; gap = 1;
                end
            end else if (gap_act) begin
                if (lcd_ready) begin
                    if (g.kind == 2'd2) check("ready_gap", gap, g.mingap);
                    gap_act = 0;
                end else begin
                    gap++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wrm = 1'b0; rdm = 1'b1; abus = 12'hFFF;
        exp_q.delete();
        push_init();
        @(posedge clk);
        @(negedge clk);
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_d", lcd_d, 0);
        check("rst_ready", lcd_ready, 0);
        check("rst_dbus_oe", dbus_oe, 1);
        check("rst_dbus_out", dbus_out, exp_read(1'b1));
        @(posedge clk);
        #1;
        rst = 1'b0; rdm = 1'b0;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [11:0] d, input logic exp_nf,
                             input bit do_model);
        bit rd1;
        rd1 = bit'($urandom_range(0, 1));
        abus = a; dbus_in = d; wrm = 1'b1; rdm = rd1;
        if (do_model) model_write(a, d);
        @(negedge clk);
        check("wr_cycle_oe", dbus_oe, 32'(rd1 && a == 12'hFFF));
        @(posedge clk);
        #1;
        wrm = 1'b0; rdm = 1'b1;
        @(negedge clk);
        check("rd_oe", dbus_oe, 32'(a == 12'hFFF));
        if (a == 12'hFFF) check("rd_data", dbus_out, exp_read(exp_nf));
        @(posedge clk);
        #1;
        rdm = 1'b0;
    endtask

    task automatic read_check(input string name);
        abus = 12'hFFF; rdm = 1'b1;
        @(negedge clk);
        check("key_rd_oe", dbus_oe, 1);
        check(name, dbus_out, exp_read(1'b1));
        @(posedge clk);
        #1;
        abus = 12'hFFE;
        @(negedge clk);
        check("other_addr_oe", dbus_oe, 0);
        @(posedge clk);
        #1;
        rdm = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!lcd_ready && t < LIMIT) begin
            tick(1);
            t++;
        end
        check("ready_reached", lcd_ready, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    function automatic logic [11:0] gen_data();
        logic [11:0] d;
        d = 12'($urandom);
        case ($urandom_range(0, 5))
            0: d[8:0] = {1'b0, 8'($urandom_range(32, 126))};
            1: d[8:0] = {1'b0, ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31))
                                                            : 8'($urandom_range(127, 255))};
            2: d[8:7] = 2'b11;
            3: begin d[8:7] = 2'b10; d[0] = 1'b1; end
            4: begin d[8:7] = 2'b10; d[0] = 1'b0; end
            default: ;
        endcase
        return d;
    endfunction

    initial begin
        logic [KEYS-1:0] nk;
        int t, target;
        rst = 1'b1; wrm = 1'b0; rdm = 1'b0; abus = '0; dbus_in = '0;
        keys_n = '1; key_model = '1;
        #1;
        do_reset();

        // Writes during power-up wait: the ninth finds the queue full.
        for (int i = 0; i < FIFO_DEPTH + 1; i++)
            cpu_write(12'hFFF, 12'(8'h41 + i), (i + 1 < FIFO_DEPTH), i < FIFO_DEPTH);
        wait_ready();

        // Directed decode cases.
        cpu_write(12'hFFF, 12'h041, 1'b1, 1); wait_ready();
        cpu_write(12'hFFF, 12'h010, 1'b1, 1); wait_ready();
        cpu_write(12'hFFF, 12'h185, 1'b1, 1); wait_ready();
        cpu_write(12'hFFF, 12'h101, 1'b1, 1); wait_ready();
        cpu_write(12'hFFF, 12'h100, 1'b1, 1); wait_ready();
        cpu_write(12'h7FF, 12'h041, 1'b1, 1); wait_ready();

        // Random bursts, never more than the queue can hold.
        for (int b = 0; b < 20; b++) begin
            int len;
            len = $urandom_range(1, FIFO_DEPTH);
            for (int i = 0; i < len; i++)
                cpu_write(($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'hFFF, gen_data(), 1'b1, 1);
            wait_ready();
        end

        // Keypad debounce.
        keys_n[3] = 1'b0; tick(DEB_CYC - 1);
        keys_n[3] = 1'b1; tick(DEB_CYC + 4);
        read_check("key_short_low");
        keys_n[3] = 1'b0; tick(DEB_CYC + 4);
        key_model[3] = 1'b0;
        read_check("key_long_low");
        for (int i = 0; i < 12; i++) begin
            nk = key_model ^ KEYS'($urandom_range(1, (1 << KEYS) - 1));
            keys_n = nk;
            if ($urandom_range(0, 1) != 0) begin
                tick(DEB_CYC + 4);
                key_model = nk;
            end else begin
                tick($urandom_range(1, DEB_CYC - 1));
                keys_n = key_model;
                tick(DEB_CYC + 4);
            end
            read_check("key_random");
        end
        keys_n = '1; tick(DEB_CYC + 4);
        key_model = '1;
        read_check("key_release");

        // Reset in the middle of a queued burst, during the second byte's low nibble.
        target = rise_cnt + 4;
        for (int i = 0; i < 4; i++) cpu_write(12'hFFF, 12'(8'h57 + i), 1'b1, 1);
        t = 0;
        while (rise_cnt < target && t < LIMIT) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("burst_reached_lo", 32'(rise_cnt >= target), 1);
        do_reset();
        wait_ready();
        tick(CHAR_CYC + 4);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
